// File: rtl/multdiv_ctrl_if.sv
// Handshake/bus bundle between the main control unit (master) and the
// mult/div sequencer (slave). `uns` exists only when MULTDIV_UNSIGNED_EN is defined.
interface multdiv_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef MULTDIV_UNSIGNED_EN
  logic             uns;
`endif
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             hi_lo_write;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef MULTDIV_UNSIGNED_EN
  modport master (output start, op, a, b, uns,
                  input  busy, done, div_zero, hi_lo_write, hi, lo);
  modport slave  (input  start, op, a, b, uns,
                  output busy, done, div_zero, hi_lo_write, hi, lo);
`else
  modport master (output start, op, a, b,
                  input  busy, done, div_zero, hi_lo_write, hi, lo);
  modport slave  (input  start, op, a, b,
                  output busy, done, div_zero, hi_lo_write, hi, lo);
`endif
endinterface

// File: rtl/multdiv_ctrl.sv
// Iterative mult/div sequencer: radix-2 Booth multiply or restoring divide,
// one step per cycle, then sign fix-up and a Hi/Lo write strobe.
// Optional unsigned mode (multu/divu) is enabled by defining MULTDIV_UNSIGNED_EN.
module multdiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  multdiv_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4,
    S_DIVZ = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_op, r_a_neg, r_b_neg, r_qm1;
  logic [WIDTH:0]   r_m;    // multiplicand (mult) or divisor magnitude (div)
  logic [WIDTH:0]   r_acc;  // Booth accumulator or partial remainder
  logic [WIDTH-1:0] r_mq;   // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_busy, r_done, r_div_zero, r_hlw;
  logic             w_busy_nxt, w_done_nxt, w_div_zero_nxt, w_hlw_nxt;
  logic             w_last, w_uns_in, w_a_neg_in, w_b_neg_in;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_hi_fix, w_lo_fix;
  logic [WIDTH:0]   w_booth, w_shift;
  logic [WIDTH+1:0] w_sub;

`ifdef MULTDIV_UNSIGNED_EN
  logic             r_uns, r_b_msb;
  assign w_uns_in = bus.uns;
`else
  assign w_uns_in = 1'b0;
`endif

  assign w_a_neg_in = bus.a[WIDTH-1] & ~w_uns_in;
  assign w_b_neg_in = bus.b[WIDTH-1] & ~w_uns_in;
  assign w_a_mag    = w_a_neg_in ? -bus.a : bus.a;
  assign w_b_mag    = w_b_neg_in ? -bus.b : bus.b;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_shift    = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]};
  assign w_sub      = {1'b0, w_shift} - {1'b0, r_m};

  // State register plus registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hlw      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_div_zero <= w_div_zero_nxt;
      r_hlw      <= w_hlw_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (!bus.op)           w_state_nxt = S_MULT;
          else if (bus.b == '0)  w_state_nxt = S_DIVZ;
          else                   w_state_nxt = S_DIV;
        end
      end
      S_MULT, S_DIV: if (w_last) w_state_nxt = S_FIX;
      S_FIX:         w_state_nxt = S_DONE;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode; div-by-zero reports in the cycle after DIVZ
  always_comb begin
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_div_zero_nxt = 1'b0;
    w_hlw_nxt      = 1'b0;
    w_busy_nxt     = (w_state_nxt == S_MULT) || (w_state_nxt == S_DIV) ||
                     (w_state_nxt == S_FIX);
    w_done_nxt     = (w_state_nxt == S_DONE) || (r_state == S_DIVZ);
    w_div_zero_nxt = (r_state == S_DIVZ);
    w_hlw_nxt      = (w_state_nxt == S_DONE);
  end

  // Booth add/sub selected by the current multiplier bit pair
  always_comb begin
    w_booth = r_acc;
    case ({r_mq[0], r_qm1})
      2'b01:   w_booth = r_acc + r_m;
      2'b10:   w_booth = r_acc - r_m;
      default: w_booth = r_acc;
    endcase
  end

  // Final sign correction for signed divide, top-bit correction for multu
  always_comb begin
    w_hi_fix = r_acc[WIDTH-1:0];
    w_lo_fix = r_mq;
    if (r_op) begin
      if (r_a_neg ^ r_b_neg) w_lo_fix = -r_mq;
      if (r_a_neg)           w_hi_fix = -r_acc[WIDTH-1:0];
    end
`ifdef MULTDIV_UNSIGNED_EN
    // Booth treats the multiplier as signed; add back 2^WIDTH*a when its MSB is set
    if (!r_op && r_uns && r_b_msb) w_hi_fix = r_acc[WIDTH-1:0] + r_m[WIDTH-1:0];
`endif
  end

  // Operand capture, iteration datapath and Hi/Lo result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_a_neg <= 1'b0;
      r_b_neg <= 1'b0;
      r_qm1   <= 1'b0;
      r_m     <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MULTDIV_UNSIGNED_EN
      r_uns   <= 1'b0;
      r_b_msb <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_qm1   <= 1'b0;
            r_a_neg <= w_a_neg_in;
            r_b_neg <= w_b_neg_in;
`ifdef MULTDIV_UNSIGNED_EN
            r_uns   <= bus.uns;
            r_b_msb <= bus.b[WIDTH-1];
`endif
            if (bus.op) begin
              r_m  <= {1'b0, w_b_mag};
              r_mq <= w_a_mag;
            end else begin
              r_m  <= {w_a_neg_in, bus.a};
              r_mq <= bus.b;
            end
          end
        end
        S_MULT: begin
          r_acc <= {w_booth[WIDTH], w_booth[WIDTH:1]};
          r_mq  <= {w_booth[0], r_mq[WIDTH-1:1]};
          r_qm1 <= r_mq[0];
          r_cnt <= r_cnt + CW'(1);
        end
        S_DIV: begin
          r_acc <= w_sub[WIDTH+1] ? w_shift : w_sub[WIDTH:0];
          r_mq  <= {r_mq[WIDTH-2:0], ~w_sub[WIDTH+1]};
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_hi <= w_hi_fix;
          r_lo <= w_lo_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_zero    = r_div_zero;
  assign bus.hi_lo_write = r_hlw;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: a driver issues operations and queues the
// expected Hi/Lo/flag/cycle; a monitor pops and compares on every done pulse.
// Unsigned cases run only when MULTDIV_UNSIGNED_EN is defined.
module tb_multdiv_ctrl;
  localparam int unsigned W = 32;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n_done = 0;
  exp_t sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  multdiv_ctrl_if #(.WIDTH(W)) bus ();
  multdiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like MIPS
  function automatic void model(input logic op, input logic uns, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] hi,
                                output logic [31:0] lo, output logic dz);
    longint sa, sb2, p, q, r;
    sa  = uns ? longint'({32'h0, a}) : longint'($signed(a));
    sb2 = uns ? longint'({32'h0, b}) : longint'($signed(b));
    dz = 1'b0; hi = m_hi; lo = m_lo;
    if (!op) begin
      p = sa * sb2; hi = p[63:32]; lo = p[31:0];
    end else if (b == 32'h0) begin
      dz = 1'b1;
    end else begin
      q = sa / sb2; r = sa % sb2; hi = r[31:0]; lo = q[31:0];
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation; optionally pulse a spurious start while busy
  task automatic issue(input logic op, input logic uns, input logic [31:0] a,
                       input logic [31:0] b, input int pulse_at);
    exp_t e;
    logic [31:0] h, l;
    logic dz;
    bit seen;
    model(op, uns, a, b, h, l, dz);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
`ifdef MULTDIV_UNSIGNED_EN
    bus.uns = uns;
`endif
    e.hi = h; e.lo = l; e.dz = dz; e.cyc = cyc + (dz ? 2 : int'(W) + 2);
    sb.push_back(e);
    if (!dz) begin m_hi = h; m_lo = l; end
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_accept", 64'(bus.busy), 64'(!dz));
    seen = 1'b0;
    for (int i = 1; i < 60 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (pulse_at != 0 && i == pulse_at) begin
          bus.start = 1'b1; bus.op = 1'($urandom); bus.a = $urandom; bus.b = $urandom;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done required=done op=%0d a=0x%0h b=0x%0h", op, a, b);
    end
  endtask

  // Monitor: protocol invariants every cycle, scoreboard compare on done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("busy_done_overlap", 64'(bus.busy & bus.done), 64'(0));
        chk("hlw_strobe", 64'(bus.hi_lo_write), 64'(bus.done & ~bus.div_zero));
        if (bus.done) begin
          n_done++;
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done actual=done required=none hi=0x%0h lo=0x%0h", bus.hi, bus.lo);
          end else begin
            e = sb.pop_front();
            chk("hi", 64'(bus.hi), 64'(e.hi));
            chk("lo", 64'(bus.lo), 64'(e.lo));
            chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  // Driver: directed cases, reset abort, ignored start, then random traffic
  initial begin
    logic [31:0] ra, rb;
    logic rop, runs;
    int d0;
    reset = 1'b0; bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
`ifdef MULTDIV_UNSIGNED_EN
    bus.uns = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_hi", 64'(bus.hi), 64'(0));
    chk("rst_lo", 64'(bus.lo), 64'(0));
    reset = 1'b1;

    issue(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, 0);
    issue(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 0);
    issue(1'b1, 1'b0, 32'd5, 32'd2, 0);
    issue(1'b1, 1'b0, 32'd5, 32'd0, 0);
    issue(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Abort a multiply at iteration 10
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    sb.delete(); m_hi = '0; m_lo = '0;
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    chk("abort_dz", 64'(bus.div_zero), 64'(0));
    chk("abort_hlw", 64'(bus.hi_lo_write), 64'(0));
    chk("abort_hi", 64'(bus.hi), 64'(0));
    chk("abort_lo", 64'(bus.lo), 64'(0));
    reset = 1'b1;

    d0 = n_done;
    issue(1'b0, 1'b0, 32'd3, 32'd4, 5);
    repeat (40) @(negedge clk);
    chk("single_done_count", 64'(n_done - d0), 64'(1));

`ifdef MULTDIV_UNSIGNED_EN
    issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 0);
    issue(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 0);
    issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      ra  = pick();
      rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : pick();
      rop = 1'($urandom);
`ifdef MULTDIV_UNSIGNED_EN
      runs = 1'($urandom);
`else
      runs = 1'b0;
`endif
      issue(rop, runs, ra, rb, 0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Iterative sequencer for the `mult`/`div` instructions. It accepts a start pulse and two operands from the main multicycle control unit. It then runs a 32-step radix-2 signed multiply (Booth) or restoring divide on its own shift registers, applies sign correction, and hands back a Hi/Lo pair with a one-cycle write strobe. While busy, the main control unit holds in a wait state on `busy`; divide-by-zero goes to it as a flag, not as a result.

## Interface
Parameters:
- `WIDTH`, 32, operand width; Hi/Lo are each `WIDTH` bits; iteration count = `WIDTH`.

Ports:
- `clk`  input  1  clock, all state changes on rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `start`  input  1  request; sampled only in IDLE.
- `op`  input  1  0 = mult, 1 = div; sampled with `start`.
- `a`  input  WIDTH  multiplicand / dividend (reg A); sampled with `start`.
- `b`  input  WIDTH  multiplier / divisor (reg B); sampled with `start`.
- `busy`  output  1  high from the cycle after acceptance through the FIX cycle.
- `done`  output  1  one-cycle completion pulse (normal or div-by-zero).
- `div_zero`  output  1  high with `done` when div had `b == 0`.
- `hi_lo_write`  output  1  one-cycle strobe to load external Hi/Lo; never high with `div_zero`.
- `hi`  output  WIDTH  mult: upper product; div: remainder.
- `lo`  output  WIDTH  mult: lower product; div: quotient.

## Operation
- States: IDLE, MULT, DIV, FIX, DONE, DIVZ.
- IDLE:
  - `start`=1 latches `a`, `b`, `op`, and clears counter.
  - `op`=0 goes to MULT.
  - `op`=1 with `b`≠0 goes to DIV.
  - `op`=1 with `b`==0 goes to DIVZ.
- MULT: Booth radix-2 on {acc, multiplier, q₋₁}, one step per cycle. Add/sub uses a `WIDTH+1`-bit signed accumulator, followed by an arithmetic right shift. After `WIDTH` steps, goes to FIX.
- DIV: restoring divide on magnitudes |a|, |b|, one quotient bit per cycle, `WIDTH+1`-bit partial remainder. After `WIDTH` steps, goes to FIX.
- FIX:
  - mult: result passes unchanged.
  - div: quotient negated if sign(a)≠sign(b); remainder takes the sign of `a` (MIPS semantics).
  - Writes `hi`/`lo`, then goes to DONE.
- DONE: `done`=1, `hi_lo_write`=1, back to IDLE.
- DIVZ: `done`=1, `div_zero`=1, `hi_lo_write`=0, `hi`/`lo` unchanged, back to IDLE.
- Arithmetic is mod 2^WIDTH. `0x80000000 / -1` gives quotient `0x80000000`, remainder 0, no flag.
- `start` outside IDLE (including DONE/DIVZ) is ignored and not queued. The requester must hold or re-pulse `start` once `done` has been seen.
- `hi`/`lo` hold their last value until the next FIX.

## Timing
- Reset (`reset`=0 at an edge), on that edge, in any state including mid-iteration:
  - state goes to IDLE;
  - `busy`, `done`, `div_zero`, `hi_lo_write` = 0;
  - `hi`, `lo`, counter and internal regs = 0.
  - The aborted operation produces no `done`.
- Let edge E be the edge that samples `start`=1 in IDLE:
  - `busy` = 1 from E through FIX.
  - Iterations occur at edges E+1 … E+WIDTH.
  - FIX occurs at edge E+WIDTH+1.
  - `done`/`hi_lo_write` are high for exactly the cycle after edge E+WIDTH+1, i.e. the 34th cycle after the start cycle for `WIDTH`=32.
  - `hi`/`lo` are valid in that same cycle.
- Div-by-zero: `done`+`div_zero` are high in the cycle after edge E+1 (2nd cycle); `busy` is never asserted.
- `busy` and `done` are never high together. The earliest next acceptance is the edge ending the DONE/DIVZ cycle's successor (IDLE).

## Configuration
- `MULTDIV_UNSIGNED_EN` defined:
  - adds input `uns` (1 bit, sampled with `start`);
  - `uns`=1 treats `a`/`b` as unsigned: mult uses a zero-extended `WIDTH+1` accumulator with the top Booth bit forced 0, div skips magnitude conversion and FIX sign correction (multu/divu).
- Not defined: port `uns` is absent, all operations are signed, and the unsigned datapath is not synthesised.

## Test plan
- mult: `a`=7, `b`=0xFFFFFFFD (-3) → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `done`+`hi_lo_write` in cycle 34, `busy` low in that cycle.
- div: `a`=0xFFFFFFF9 (-7), `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; then `a`=7, `b`=0xFFFFFFFE → `lo`=0xFFFFFFFD, `hi`=1.
- div-by-zero: `a`=5, `b`=0 after a prior result `hi`=0x1,`lo`=0x2 → `done`=`div_zero`=1 in cycle 2, `hi_lo_write`=0, `hi`/`lo` still 0x1/0x2.
- mult corner: `a`=`b`=0x80000000 → `hi`=0x40000000, `lo`=0; div `a`=0x80000000, `b`=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Reset: `reset`=0 at iteration 10 of a mult → next cycle all outputs 0, no `done` ever for it. A new `start` with `a`=3, `b`=4 then gives `lo`=12 in cycle 34. A `start` pulse during `busy` is ignored: exactly one `done`.
- With `MULTDIV_UNSIGNED_EN`, `uns`=1: `a`=0xFFFFFFFF, `b`=2 mult → `hi`=1, `lo`=0xFFFFFFFE; div → `lo`=0x7FFFFFFF, `hi`=1.
